// File: rtl/ctrl_pkg.sv
// Shared constants for the processor control unit: state codes, opcodes, ALU selects.
// Optional single-step FETCH gating is enabled by defining CTRL_SINGLE_STEP_EN.
package ctrl_pkg;

  localparam int unsigned ST_W = 4;

  localparam logic [3:0] ST_INIT   = 4'h0;
  localparam logic [3:0] ST_FETCH  = 4'h1;
  localparam logic [3:0] ST_DECODE = 4'h2;
  localparam logic [3:0] ST_LOAD_A = 4'h3;
  localparam logic [3:0] ST_LOAD_B = 4'h4;
  localparam logic [3:0] ST_ADD    = 4'h5;
  localparam logic [3:0] ST_SUB    = 4'h6;
  localparam logic [3:0] ST_STORE  = 4'h7;
  localparam logic [3:0] ST_NOOP   = 4'h8;
  localparam logic [3:0] ST_HALT   = 4'h9;
  localparam logic [3:0] ST_ALU_X  = 4'hA;

  localparam int unsigned OPC_NOOP  = 0;
  localparam int unsigned OPC_STORE = 1;
  localparam int unsigned OPC_LOAD  = 2;
  localparam int unsigned OPC_ADD   = 3;
  localparam int unsigned OPC_SUB   = 4;
  localparam int unsigned OPC_HALT  = 5;
  localparam int unsigned OPC_AND   = 6;
  localparam int unsigned OPC_OR    = 7;
  localparam int unsigned OPC_XOR   = 8;

  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_AND = 3;
  localparam int unsigned ALU_OR  = 4;
  localparam int unsigned ALU_XOR = 5;

  // Execute state entered from DECODE; FETCH marks an undefined opcode.
  function automatic logic [3:0] decode_target(input int unsigned op);
    logic [3:0] st;
    st = ST_FETCH;
    case (op)
      OPC_NOOP:                  st = ST_NOOP;
      OPC_STORE:                 st = ST_STORE;
      OPC_LOAD:                  st = ST_LOAD_A;
      OPC_ADD:                   st = ST_ADD;
      OPC_SUB:                   st = ST_SUB;
      OPC_HALT:                  st = ST_HALT;
      OPC_AND, OPC_OR, OPC_XOR:  st = ST_ALU_X;
      default:                   st = ST_FETCH;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ctrl_fsm_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ctrl_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_fsm_gen.sv
// Multi-cycle Moore control unit: fetch, decode, execute with configurable memory latency.
// Define CTRL_SINGLE_STEP_EN to add the Step port that gates FETCH.
module ctrl_fsm_gen
  import ctrl_pkg::*;
#(
  parameter int unsigned IR_W    = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RF_AW   = 4,
  parameter int unsigned D_AW    = 8,
  parameter int unsigned ALU_SW  = 3,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   IR,
  input  logic              Resume,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic              PC_clr,
  output logic              PC_up,
  output logic              IR_ld,
  output logic              D_wr,
  output logic              RF_s,
  output logic              RF_W_en,
  output logic [RF_AW-1:0]  RF_W_addr,
  output logic [RF_AW-1:0]  RF_Ra_addr,
  output logic [RF_AW-1:0]  RF_Rb_addr,
  output logic [D_AW-1:0]   D_Addr,
  output logic [ALU_SW-1:0] ALU_s0,
  output logic [3:0]        OutState,
  output logic [3:0]        NextState,
  output logic              Halted,
  output logic              Illegal,
  output logic [CNT_W-1:0]  Retired
);

  localparam int unsigned WC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  next_state;
  logic [ST_W-1:0]  dec_target;
  logic [WC_W-1:0]  wait_cnt;
  logic             wait_done;
  logic             step_ok;
  logic             retire_c;

  logic [OP_W-1:0]  opcode;
  logic [RF_AW-1:0] ra;
  logic [RF_AW-1:0] rb;
  logic [RF_AW-1:0] rd;
  logic [D_AW-1:0]  ld_addr;
  logic [D_AW-1:0]  st_addr;

  assign opcode  = IR[IR_W-1 -: OP_W];
  assign ra      = IR[IR_W-OP_W-1 -: RF_AW];
  assign rb      = IR[IR_W-OP_W-RF_AW-1 -: RF_AW];
  assign rd      = IR[RF_AW-1:0];
  assign ld_addr = IR[RF_AW +: D_AW];
  assign st_addr = IR[D_AW-1:0];

`ifdef CTRL_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  assign dec_target = decode_target(32'(opcode));
  assign wait_done  = (wait_cnt == WC_W'(MEM_LAT - 1));

  // State register and LOAD_A wait counter
  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= ST_INIT;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= ((state == ST_LOAD_A) && !wait_done) ? wait_cnt + WC_W'(1) : '0;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = ST_INIT;
    case (state)
      ST_INIT:   next_state = ST_FETCH;
      ST_FETCH:  next_state = step_ok ? ST_DECODE : ST_FETCH;
      ST_DECODE: next_state = dec_target;
      ST_LOAD_A: next_state = wait_done ? ST_LOAD_B : ST_LOAD_A;
      ST_LOAD_B, ST_ADD, ST_SUB, ST_STORE, ST_NOOP, ST_ALU_X:
                 next_state = ST_FETCH;
      ST_HALT:   next_state = Resume ? ST_FETCH : ST_HALT;
      default:   next_state = ST_INIT;
    endcase
  end

  // Moore output decode from state and IR fields
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    D_Addr     = '0;
    ALU_s0     = '0;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    retire_c   = 1'b0;
    case (state)
      ST_INIT:   PC_clr = 1'b1;
      ST_FETCH: begin
        IR_ld = step_ok;
        PC_up = step_ok;
      end
      ST_DECODE: begin
        Illegal  = (dec_target == ST_FETCH);
        retire_c = (dec_target == ST_HALT);
      end
      ST_LOAD_A: D_Addr = ld_addr;
      ST_LOAD_B: begin
        D_Addr    = ld_addr;
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = rd;
        retire_c  = 1'b1;
      end
      ST_ADD, ST_SUB, ST_ALU_X: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rd;
        RF_W_en    = 1'b1;
        retire_c   = 1'b1;
        if (state == ST_ADD)      ALU_s0 = ALU_SW'(ALU_ADD);
        else if (state == ST_SUB) ALU_s0 = ALU_SW'(ALU_SUB);
        else                      ALU_s0 = ALU_SW'(opcode - OP_W'(3));
      end
      ST_STORE: begin
        D_wr       = 1'b1;
        D_Addr     = st_addr;
        RF_Ra_addr = ra;
        retire_c   = 1'b1;
      end
      ST_NOOP:   retire_c = 1'b1;
      ST_HALT:   Halted   = 1'b1;
      default:   ;
    endcase
  end

  assign OutState  = state;
  assign NextState = next_state;

  ctrl_sat_counter #(.W(CNT_W)) u_retired (
    .Clk   (Clk),
    .clear (reset),
    .inc   (retire_c),
    .q     (Retired)
  );

endmodule
